// File: rtl/decode_issue_ctrl_pkg.sv
// Shared types and constants for the fetch -> dual-issue decode sequencing path.
// Includes the RAW hazard test applied to the head instruction pair.
package decode_issue_ctrl_pkg;

    localparam int DIC_XLEN = 32;

    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int OPC_LSB = 0;
    localparam int OPC_W   = 7;
    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int REG_W   = 5;

    localparam logic [0:0] ST_PAIR    = 1'b0;
    localparam logic [0:0] ST_SPLIT_B = 1'b1;

    typedef struct packed {
        logic [DIC_XLEN-1:0] instA;
        logic [DIC_XLEN-1:0] pcA;
        logic [DIC_XLEN-1:0] instB;
        logic [DIC_XLEN-1:0] pcB;
        logic                validB;
    } dic_entry_t;

    // rs fields are compared whatever B's format; a false hazard only costs a cycle
    function automatic logic raw_hazard(input logic [31:0] inst_a,
                                        input logic [31:0] inst_b,
                                        input logic        valid_b);
        logic [REG_W-1:0] rd;
        logic [OPC_W-1:0] opc;
        logic             writes;
        rd     = inst_a[RD_LSB +: REG_W];
        opc    = inst_a[OPC_LSB +: OPC_W];
        writes = (opc != OPC_STORE) && (opc != OPC_BRANCH);
        return valid_b && writes && (rd != '0) &&
               ((inst_b[RS1_LSB +: REG_W] == rd) || (inst_b[RS2_LSB +: REG_W] == rd));
    endfunction

endpackage

// File: rtl/decode_issue_ctrl_if.sv
// Fetch-side and issue-side handshake bundle of decode_issue_ctrl.
// slave = the controller, master = fetch/dispatch environment.
interface decode_issue_ctrl_if #(
    parameter int XLEN = 32
);
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] fetch_instA;
    logic [XLEN-1:0] fetch_instB;
    logic [XLEN-1:0] fetch_pcA;
    logic [XLEN-1:0] fetch_pcB;
    logic            fetch_validB;

    logic            issue_valid;
    logic            issue_ready;
    logic [XLEN-1:0] issue_instA;
    logic [XLEN-1:0] issue_instB;
    logic [XLEN-1:0] issue_pcA;
    logic [XLEN-1:0] issue_pcB;
    logic            issue_validB;
    logic            split_active;

    modport master (
        output fetch_valid, fetch_instA, fetch_instB, fetch_pcA, fetch_pcB, fetch_validB,
        output issue_ready,
        input  fetch_ready,
        input  issue_valid, issue_instA, issue_instB, issue_pcA, issue_pcB, issue_validB,
        input  split_active
    );

    modport slave (
        input  fetch_valid, fetch_instA, fetch_instB, fetch_pcA, fetch_pcB, fetch_validB,
        input  issue_ready,
        output fetch_ready,
        output issue_valid, issue_instA, issue_instB, issue_pcA, issue_pcB, issue_validB,
        output split_active
    );
endinterface

// File: rtl/decode_pair_fifo.sv
// Instruction-pair queue: storage, pointers and occupancy count with a head read port.
// Pointers wrap naturally, so DEPTH must be a power of two.
module decode_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 129
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [PTR_W:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_wr_en = i_push && !i_clear;
    assign w_rd_en = i_pop && !i_clear;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/decode_issue_ctrl.sv
// Presents queued instruction pairs to the dual-issue decoder, splitting a pair into
// two single-slot issues when B reads A's destination; flush discards everything.
module decode_issue_ctrl
    import decode_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    decode_issue_ctrl_if.slave   bus
);
    localparam int ENTRY_W = 4 * XLEN + 1;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [0:0]         r_state;
    logic [CNT_W-1:0]   w_count;
    logic [ENTRY_W-1:0] w_push_data;
    logic [ENTRY_W-1:0] w_head;
    logic [XLEN-1:0]    w_head_instA;
    logic [XLEN-1:0]    w_head_pcA;
    logic [XLEN-1:0]    w_head_instB;
    logic [XLEN-1:0]    w_head_pcB;
    logic               w_head_validB;
    logic               w_nonempty;
    logic               w_push;
    logic               w_pop;
    logic               w_fire;
    logic               w_hazard;
    logic               w_issue_valid;

    // Entry layout {instA, pcA, instB, pcB, validB}, MSB first
    assign w_push_data = {bus.fetch_instA, bus.fetch_pcA, bus.fetch_instB,
                          bus.fetch_pcB, bus.fetch_validB};

    assign w_head_validB = w_head[0];
    assign w_head_pcB    = w_head[1 +: XLEN];
    assign w_head_instB  = w_head[XLEN + 1 +: XLEN];
    assign w_head_pcA    = w_head[2 * XLEN + 1 +: XLEN];
    assign w_head_instA  = w_head[3 * XLEN + 1 +: XLEN];

    assign w_nonempty      = (w_count != '0);
    assign bus.fetch_ready = (w_count != CNT_FULL);
    assign w_push          = bus.fetch_valid && bus.fetch_ready && !flush;

    assign w_hazard = raw_hazard(w_head_instA[31:0], w_head_instB[31:0], w_head_validB);

    assign w_issue_valid = (r_state == ST_SPLIT_B) || w_nonempty;
    assign w_fire        = w_issue_valid && bus.issue_ready;
    // The first half of a split pair leaves the entry at the head for the B issue
    assign w_pop         = w_fire && ((r_state == ST_SPLIT_B) || !w_hazard);

    decode_pair_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clear     (flush),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_state <= ST_PAIR;
        end else if (w_fire) begin
            case (r_state)
                ST_PAIR:    r_state <= w_hazard ? ST_SPLIT_B : ST_PAIR;
                ST_SPLIT_B: r_state <= ST_PAIR;
                default:    r_state <= ST_PAIR;
            endcase
        end
    end

    always_comb begin
        bus.issue_instA  = '0;
        bus.issue_pcA    = '0;
        bus.issue_instB  = '0;
        bus.issue_pcB    = '0;
        bus.issue_validB = 1'b0;
        if (r_state == ST_SPLIT_B) begin
            bus.issue_instA = w_head_instB;
            bus.issue_pcA   = w_head_pcB;
        end else if (w_nonempty) begin
            bus.issue_instA = w_head_instA;
            bus.issue_pcA   = w_head_pcA;
            if (!w_hazard && w_head_validB) begin
                bus.issue_validB = 1'b1;
                bus.issue_instB  = w_head_instB;
                bus.issue_pcB    = w_head_pcB;
            end
        end
    end

    assign bus.issue_valid  = w_issue_valid;
    assign bus.split_active = (r_state == ST_SPLIT_B);

endmodule

// File: doc/decode_issue_ctrl.md
# decode_issue_ctrl

Sequencing controller between fetch and the dual-issue decoder.
- Buffers fetched instruction pairs in a small FIFO and presents one pair per cycle to the decoder's A/B slots.
- Splits a pair into two single-slot issues when instruction B reads the register that instruction A writes. Both slots decode in parallel against the RF, so B could not otherwise see A's result.
- Discards everything on a pipeline flush.

## Interface
Parameters:
- DEPTH, 4, queue entries (instruction pairs), power of two, ≥2
- XLEN, 32, instruction and PC width

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  discard queue and split state
- fetch_valid  in  1  fetch offers a pair
- fetch_ready  out  1  queue can accept (= count != DEPTH)
- fetch_instA, fetch_instB  in  XLEN  older / younger instruction
- fetch_pcA, fetch_pcB  in  XLEN  their PCs
- fetch_validB  in  1  slot B occupied; slot A always occupied when fetch_valid
- issue_valid  out  1  decoder inputs hold a valid pair
- issue_ready  in  1  downstream dispatch accepts this cycle
- issue_instA, issue_instB  out  XLEN  to decoder instA/instB
- issue_pcA, issue_pcB  out  XLEN  to decoder pcA/pcB
- issue_validB  out  1  slot B meaningful
- split_active  out  1  state == SPLIT_B (debug/perf)

## Operation
- Storage: DEPTH entries of {instA, pcA, instB, pcB, validB}; wr_ptr, rd_ptr ($clog2(DEPTH) bits, natural wrap); count ($clog2(DEPTH)+1 bits).
- Push = fetch_valid & fetch_ready. Pop = head entry fully issued (see FSM). Push and pop in the same cycle leave count unchanged. fetch_ready does not look at pop, so a full queue rejects a push even when a pop happens that cycle.
- Hazard (combinational, head entry):
  - rdA = instA[11:7]
  - A writes = opcode instA[6:0] is neither 0100011 (store) nor 1100011 (branch)
  - hazard = validB & A writes & rdA != 0 & (instB[19:15] == rdA | instB[24:20] == rdA)
  - rs fields are compared regardless of B's format. A false hazard only costs a cycle.
- FSM, 2 states:
  - PAIR:
    - issue_valid = count != 0.
    - No hazard: outputs = head entry unchanged. Handshake pops the entry; stay in PAIR.
    - Hazard: outputs = A in slot A, issue_validB = 0, issue_instB/pcB = 0. Handshake goes to SPLIT_B with no pop.
  - SPLIT_B:
    - issue_valid = 1. Head's B is presented in slot A (issue_instA = instB, issue_pcA = pcB), issue_validB = 0.
    - Handshake pops the entry and returns to PAIR.
- Whenever issue_validB = 0, issue_instB/pcB drive 0.
- Flush (highest priority, same cycle as any push/handshake):
  - next state PAIR; pointers and count go to 0.
  - A push in the flush cycle is dropped.
- Outputs may change only after an accepted handshake. While issue_valid & !issue_ready, all issue_* are stable.

## Timing
- Reset (rst_n = 0 at edge):
  - state PAIR, pointers/count 0.
  - fetch_ready = 1, issue_valid = 0, issue_validB = 0, issue_inst*/pc* = 0, split_active = 0.
  - Storage contents need not be reset.
- Push-to-issue latency: 1 cycle. A pair accepted at edge N appears on issue_* after edge N, if the queue was empty.
- Issue outputs are combinational from registered head/state, with no path from issue_ready to issue_*. fetch_ready is a function of count only.
- Throughput: 1 pair/cycle when hazard-free. A hazard pair takes 2 issue handshakes.
- Empty: issue_valid = 0; issue_ready is ignored.
- Full: fetch_ready = 0; fetch inputs are ignored.
- Reset or flush while in SPLIT_B: the pending B is discarded.

## Structure
- The shared package carries:
  - OPC_STORE = 7'b0100011, OPC_BRANCH = 7'b1100011
  - field position constants for rd/rs1/rs2
  - the entry struct {instA, pcA, instB, pcB, validB}, also used by fetch
- One sub-module: decode_pair_fifo. It holds the storage, pointers, count and push/pop, with a head-entry read port. The FSM, hazard check and output muxing live in the top.

## Test plan
- Reset then idle:
  - fetch_ready = 1, issue_valid = 0, all issue_* = 0.
- Independent pair:
  - push instA = 0x00500093 (addi x1,x0,5) @0x100, instB = 0x00A00113 (addi x2,x0,10) @0x104, issue_ready = 1.
  - Next cycle: issue_validB = 1, both slots as pushed. Following cycle: queue empty.
- RAW split:
  - instA = addi x1,x0,5; instB = 0x00108193 (addi x3,x1,1).
  - First handshake: slot A = 0x00500093, issue_validB = 0.
  - Second handshake: slot A = 0x00108193 @0x104, split_active = 1, then the entry is popped.
- False-hazard exclusions:
  - A = store 0x00112023 (sw x1,0(x2)) with B reading x0 or x1: no split.
  - A with rd = x0: no split.
- Full/backpressure:
  - DEPTH pushes with issue_ready = 0 → fetch_ready = 0. Issue outputs are held stable, and the (DEPTH+1)th offer is not accepted.
  - Then one handshake → fetch_ready = 1.
- Flush mid-split:
  - in SPLIT_B with 2 entries queued, assert flush together with fetch_valid.
  - Next cycle: issue_valid = 0, count = 0, split_active = 0, and the concurrent push is lost.
